// File: rtl/cache_refill_ctrl.sv
// Miss-handling sequencer: optional dirty-victim writeback, block refill, then a
// one-cycle fill_valid pulse to the cache. Sticky timeout flag and saturating counters.
module cache_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_in,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              dirty_evicted,
  input  logic [ADDR_W-1:0] evicted_address,
  input  logic [LINE_W-1:0] victim_data,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_error,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;
  localparam logic [1:0] S_RESPOND   = 2'd3;

  // The counter must be able to hold TIMEOUT-1, the value it lands on at expiry.
  localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] fill_addr;
  logic              accept;
  logic              in_mem_phase;
  logic              timeout_hit;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] victim_line;
  logic              unused_low_bits;

  assign req_line        = {req_addr[ADDR_W-1:6], 6'b0};
  assign victim_line     = {evicted_address[ADDR_W-1:6], 6'b0};
  assign unused_low_bits = ^{req_addr[5:0], evicted_address[5:0]};

  assign mem_req    = (state == S_WRITEBACK) || (state == S_REFILL);
  assign mem_we     = (state == S_WRITEBACK);
  assign fill_valid = (state == S_RESPOND);
  assign stall      = (state != S_IDLE) || miss_in;

  assign accept       = (state == S_IDLE) && miss_in;
  assign in_mem_phase = mem_req;
  // An ack in the expiry cycle takes priority over the timeout.
  assign timeout_hit  = in_mem_phase && !mem_ack && (to_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (miss_in) state_next = dirty_evicted ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: begin
        if (mem_ack)          state_next = S_REFILL;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_REFILL: begin
        if (mem_ack)          state_next = S_RESPOND;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Restarts per phase so writeback and refill each get the full wait budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (in_mem_phase) begin
      if (mem_ack) to_cnt <= '0;
      else         to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_addr <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      fill_addr <= req_line;
      mem_addr  <= dirty_evicted ? victim_line : req_line;
      mem_wdata <= victim_data;
    end else if ((state == S_WRITEBACK) && mem_ack) begin
      mem_addr <= fill_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                fill_data <= '0;
    else if ((state == S_REFILL) && mem_ack) fill_data <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mem_error <= 1'b0;
    else if (timeout_hit) mem_error <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (accept && (miss_count != {CNT_W{1'b1}}))
        miss_count <= miss_count + 1'b1;
      if ((state == S_WRITEBACK) && mem_ack && (wb_count != {CNT_W{1'b1}}))
        wb_count <= wb_count + 1'b1;
    end
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling sequencer between the 4-way write-back/write-allocate cache (64B blocks) and the backing RAM.
- On a cache miss it runs an optional dirty-victim writeback, then a block refill, then hands the 512-bit line to the cache with a one-cycle ready pulse.
- Stalls the requester for the whole sequence.
- Keeps sticky timeout error status and saturating miss/writeback counters.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 512, line width in bits (64B block)
- TIMEOUT, 256, max cycles a RAM request may wait for mem_ack; minimum 2
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- miss_in  input  1  cache miss indication (combinational from cache)
- req_addr  input  ADDR_W  address that missed
- dirty_evicted  input  1  victim line is dirty (valid with miss_in)
- evicted_address  input  ADDR_W  victim line base address
- victim_data  input  LINE_W  victim line contents (valid with miss_in)
- fill_valid  output  1  one-cycle pulse: fill_data is valid (drives cache ram_ready)
- fill_data  output  LINE_W  refilled line (drives cache ram_in)
- stall  output  1  requester must hold its access
- mem_req  output  1  RAM request, held until mem_ack
- mem_we  output  1  1 = writeback, 0 = refill read
- mem_addr  output  ADDR_W  line-aligned RAM address
- mem_wdata  output  LINE_W  writeback data
- mem_ack  input  1  RAM completion pulse (data valid on a read)
- mem_rdata  input  LINE_W  RAM read data
- mem_error  output  1  sticky timeout flag
- miss_count  output  CNT_W  accepted misses, saturating
- wb_count  output  CNT_W  completed writebacks, saturating

Behaviour:
- Reset (async, immediate): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_valid=0, fill_data=0, mem_error=0, counters=0, timeout counter=0. Reset mid-sequence abandons it; no fill_valid is issued.
- States: IDLE, WRITEBACK, REFILL, RESPOND. mem_req, mem_we and fill_valid are decoded from state only (Moore outputs).
- stall = (state==IDLE & miss_in) | (state!=IDLE). This is the only combinational input-to-output path.
- IDLE, on a clock edge with miss_in=1:
  - latch fill_addr = {req_addr[ADDR_W-1:6], 6'b0}
  - latch victim addr = {evicted_address[ADDR_W-1:6], 6'b0} and victim_data
  - miss_count++ (saturate at all-ones)
  - timeout counter := 0
  - go to WRITEBACK if dirty_evicted, else REFILL
- miss_in is ignored in all states other than IDLE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr=victim addr, mem_wdata=latched victim data. On mem_ack: wb_count++ (saturating), timeout counter := 0, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=fill_addr. On mem_ack: fill_data := mem_rdata, go to RESPOND.
- RESPOND: fill_valid=1 for exactly one cycle; next state IDLE. fill_data holds its value until the next refill capture.
- mem_ack is sampled only in WRITEBACK/REFILL; an ack arriving in the same cycle as entry into the state counts (zero-wait RAM). A stray ack in IDLE or RESPOND is ignored.
- Timeout:
  - The counter increments each cycle spent in WRITEBACK/REFILL without mem_ack.
  - When it reaches TIMEOUT-1 with no ack: mem_error := 1 (sticky until rst), go to IDLE, no fill_valid, stall released.
  - Ack and expiry in the same cycle: ack wins.
- Latency, clean miss, ack on first REFILL cycle: miss accepted at edge E0; REFILL during cycle 1; RESPOND (fill_valid) in cycle 2; IDLE in cycle 3. A dirty miss adds one WRITEBACK cycle per ack wait.
- Back-to-back: a miss present in the first IDLE cycle after RESPOND is accepted at that edge.

Test Plan:
- Clean miss at req_addr=0x0000_1234, ack on first REFILL cycle with mem_rdata=pattern A → mem_addr=0x0000_1200, mem_we=0; fill_valid high exactly in cycle 2 with fill_data=A; stall high cycles 0-2; miss_count=1, wb_count=0.
- Dirty miss, evicted_address=0x0004_0040, victim_data=B, req_addr=0x0000_2000, ack after 3 wait cycles per phase:
  - WRITEBACK phase: mem_we=1, mem_addr=0x0004_0040, mem_wdata=B
  - REFILL phase: mem_we=0, mem_addr=0x0000_2000
  - after both: wb_count=1, single fill_valid pulse
- TIMEOUT=4, no ack → after 3 REFILL cycles mem_error=1, state IDLE, stall=0, no fill_valid. mem_error stays 1 through later successful misses and clears only on rst.
- Assert rst during REFILL while mem_req=1 → mem_req drops asynchronously; no fill_valid after release; counters=0.
- CNT_W=2, five clean misses → miss_count reads 1, 2, 3, 3, 3. A stray mem_ack in IDLE causes no state change.
- miss_in held high through a full sequence → exactly one sequence per IDLE acceptance, so miss_count increments once per RESPOND→IDLE return.
